// File: rtl/ram_block_reader_pkg.sv
// Shared constants for the RAM block reader and the RAM wrappers it drives.
package ram_block_reader_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/ram_block_reader_skid.sv
// Two-entry output FIFO between the RAM read pipe and the stream consumer.
module ram_block_reader_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [1:0][DATA_W-1:0] mem;
  logic                   wp, rp;

  // The reader never pushes into a full buffer or pops an empty one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/ram_block_reader.sv
// Owns a single-port synchronous RAM for one operation: streams a block out or fills it.
module ram_block_reader
  import ram_block_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clken,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr, last_addr;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] fill;
  logic [1:0]        cnt;
  logic              inflight, issue, access, pop, last;

  ram_block_reader_skid #(.DATA_W(DATA_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (ram_q),
    .pop       (pop),
    .head      (out_data),
    .count     (cnt)
  );

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign last      = (rem == (ADDR_W+1)'(1));

  always_comb begin
    issue = 1'b0;
    nxt   = state;
    case (state)
      IDLE: begin
        // Zero-length jobs pass through DRAIN, which exits at once.
        if (start) begin
          if (length == '0)    nxt = DRAIN;
          else if (clear_mode) nxt = CLEAR;
          else                 nxt = READ;
        end
      end
      CLEAR: if (last) nxt = FINISH;
      READ: begin
        issue = (({1'b0, cnt} + {2'b0, inflight}) - {2'b0, pop}) < 3'd2;
        if (issue && last) nxt = DRAIN;
      end
      DRAIN:  if (!inflight && (cnt == {1'b0, pop})) nxt = FINISH;
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign access      = (state == CLEAR) || issue;
  assign ram_clken   = access;
  assign ram_wren    = (state == CLEAR);
  assign ram_data    = (state == CLEAR) ? fill : '0;
  assign ram_address = access ? addr : last_addr;
  assign busy        = (state == CLEAR) || (state == READ) || (state == DRAIN);
  assign done        = (state == FINISH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      last_addr <= '0;
      rem       <= '0;
      fill      <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= nxt;
      inflight <= issue;
      if (state == IDLE && start) begin
        addr <= base_addr;
        rem  <= length;
        fill <= fill_data;
      end else if (access) begin
        addr      <= addr + 1'b1;
        rem       <= rem - 1'b1;
        last_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_block_reader.sv
// Directed bench for ram_block_reader with a behavioural single-port RAM.
module tb_ram_block_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, clear_mode = 1'b0, out_ready = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] length = '0;
  logic [7:0]  fill_data = '0;
  logic        busy, done, ram_clken, ram_wren, out_valid;
  logic [10:0] ram_address;
  logic [7:0]  ram_data, out_data;
  logic [7:0]  ram_q = '0;

  logic [7:0]  mem [2048];
  logic [7:0]  ref_mem [2048];
  logic        tb_we = 1'b0;
  logic [10:0] tb_addr = '0;
  logic [7:0]  tb_wdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  ram_block_reader dut (
    .clock(clock), .reset(reset), .start(start), .clear_mode(clear_mode),
    .base_addr(base_addr), .length(length), .fill_data(fill_data),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_clken(ram_clken),
    .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (ram_clken) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      else          ram_q <= mem[ram_address];
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, ram_address, 0);
    chk({tag, "_clken"}, ram_clken, 0);
    chk({tag, "_wren"}, ram_wren, 0);
    chk({tag, "_wdata"}, ram_data, 0);
    chk({tag, "_odata"}, out_data, 0);
    chk({tag, "_ovalid"}, out_valid, 0);
  endtask

  // One read operation; every transfer is scored against ref_mem.
  task automatic run_read(input logic [10:0] base, input logic [11:0] len,
                          input logic [15:0] pat, input int plen,
                          input bit poke, input bit lat);
    int cn, words, dones, issued, first_v, last_x, done_c, limit;
    logic [10:0] ea;
    words = 0; dones = 0; issued = 0; first_v = -1; last_x = -1; done_c = -1;
    limit = int'(len) + 40;
    start = 1'b1; clear_mode = 1'b0; base_addr = base; length = len;
    fill_data = 8'h5A; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    cn = 1;
    while (cn < limit && !(dones > 0 && cn > done_c + 3)) begin
      out_ready = (cn - 1 < plen) ? pat[cn-1] : 1'b1;
      start = poke && (cn == 2);
      #1;
      if (cn == 1) chk("busy_after_start", busy, 1);
      chk("outstanding_le2", (issued - words) <= 2, 1);
      if (issued - words >= 2 && !out_ready) chk("clken_when_full", ram_clken, 0);
      if (ram_clken) begin
        ea = base + 11'(issued);
        chk("rd_wren", ram_wren, 0);
        chk("rd_addr", ram_address, ea);
        issued++;
      end
      if (out_valid && out_ready) begin
        ea = base + 11'(words);
        chk("rd_data", out_data, ref_mem[ea]);
        if (words == 0) first_v = cn;
        last_x = cn;
        words++;
      end
      if (done) begin
        dones++;
        done_c = cn;
        chk("busy_in_done", busy, 0);
      end
      cyc();
      cn++;
    end
    start = 1'b0;
    chk("rd_word_count", words, len);
    chk("rd_issue_count", issued, len);
    chk("rd_done_count", dones, 1);
    if (lat) begin
      chk("first_valid_latency", first_v, 3);
      chk("done_after_last", done_c, last_x + 1);
    end
  endtask

  initial begin
    int cn, words, done_c, clk_seen;
    logic [10:0] ea;
    // Reset state
    #2 reset = 1'b1;
    #1 chk_idle_outputs("reset");
    for (int a = 0; a < 2048; a++) begin
      tb_we = 1'b1; tb_addr = 11'(a); tb_wdata = 8'((a * 7 + 3) & 8'hFF);
      ref_mem[a] = 8'((a * 7 + 3) & 8'hFF);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      tb_addr = 11'h010 + 11'(i);
      tb_wdata = (i == 4) ? 8'h77 : 8'hA1 + 8'(i * 8'h11);
      ref_mem[tb_addr] = tb_wdata;
      cyc();
    end
    tb_addr = 11'h020; tb_wdata = 8'h3C; ref_mem[11'h020] = 8'h3C;
    cyc();
    tb_we = 1'b0;
    chk_idle_outputs("reset_hold");
    reset = 1'b0;
    cyc();
    chk_idle_outputs("post_reset");

    // Read without backpressure: A1,B2,C3,D4 at start+3..+6
    chk("pre_A1", ref_mem[11'h010], 8'hA1);
    chk("pre_D4", ref_mem[11'h013], 8'hD4);
    run_read(11'h010, 12'd4, 16'h0, 0, 1'b0, 1'b1);

    // Backpressure 1,0,0,1,0,1,1 (LSB first)
    run_read(11'h010, 12'd4, 16'b110_1001, 7, 1'b0, 1'b0);

    // Start pulsed while busy is ignored
    run_read(11'h010, 12'd5, 16'b0101_0101, 8, 1'b1, 1'b0);

    // Zero length: done at start+2, no RAM access
    start = 1'b1; length = 12'd0; base_addr = 11'h100; clear_mode = 1'b0;
    cyc();
    start = 1'b0;
    done_c = -1; clk_seen = 0;
    for (cn = 1; cn <= 5; cn++) begin
      #1;
      if (ram_clken) clk_seen++;
      if (done) done_c = cn;
      cyc();
    end
    chk("len0_done_cycle", done_c, 2);
    chk("len0_no_access", clk_seen, 0);

    // Full-depth read from a non-zero base
    run_read(11'h005, 12'd2048, 16'h0, 0, 1'b0, 1'b0);

    // Clear with wrap
    start = 1'b1; clear_mode = 1'b1; base_addr = 11'h7FE; length = 12'd4;
    fill_data = 8'h00; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    done_c = -1;
    for (cn = 1; cn <= 7; cn++) begin
      #1;
      if (cn <= 4) begin
        ea = 11'h7FE + 11'(cn - 1);
        chk("clr_clken", ram_clken, 1);
        chk("clr_wren", ram_wren, 1);
        chk("clr_addr", ram_address, ea);
        chk("clr_wdata", ram_data, 8'h00);
        chk("clr_busy", busy, 1);
      end
      chk("clr_no_valid", out_valid, 0);
      if (done) done_c = cn;
      cyc();
    end
    chk("clr_done_cycle", done_c, 5);
    chk("clr_mem_7fe", mem[11'h7FE], 8'h00);
    chk("clr_mem_7ff", mem[11'h7FF], 8'h00);
    chk("clr_mem_000", mem[11'h000], 8'h00);
    chk("clr_mem_001", mem[11'h001], 8'h00);
    chk("clr_mem_002", mem[11'h002], 8'h11);

    // Reset mid-read after two transfers
    start = 1'b1; clear_mode = 1'b0; base_addr = 11'h010; length = 12'd8; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    words = 0;
    for (cn = 1; cn < 20 && words < 2; cn++) begin
      #1;
      if (out_valid && out_ready) words++;
      if (words < 2) cyc();
    end
    chk("midrst_two_words", words, 2);
    reset = 1'b1;
    #1 chk_idle_outputs("midrst");
    cyc(); cyc();
    reset = 1'b0;
    done_c = 0;
    for (cn = 0; cn < 5; cn++) begin
      #1;
      if (done || busy || out_valid) done_c++;
      cyc();
    end
    chk("midrst_quiet", done_c, 0);
    run_read(11'h020, 12'd1, 16'h0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
